led_ws2812_frame_controller: RTL and testbench
==============================================

LED_WS2812_FRAME_CONTROLLER -- requirements
Module: led_ws2812_frame_controller

Interface
REQ-001 SHALL have no parameters; sizes are fixed: 16-entry RGB frame, two banks (front/back).
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port `clk__enable`, input, 1 bit: clock enable; state updates only when it is 1.
REQ-004 SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port `host_wr_valid`, input, 1 bit: write the host colour into the back bank this cycle.
REQ-006 SHALL have port `host_wr_index`, input, 4 bits: LED index written.
REQ-007 SHALL have port `host_wr_rgb`, input, 24 bits: {red[23:16], green[15:8], blue[7:0]}.
REQ-008 SHALL have port `host_swap_req`, input, 1 bit: single-cycle pulse requesting a bank swap at the next frame start.
REQ-009 SHALL have port `cfg_num_leds`, input, 5 bits: chain length, 0..16.
REQ-010 SHALL have port `cfg_divider`, input, 8 bits: clock cycles per 400 ns.
REQ-011 SHALL have port `led_request__ready`, input, 1 bit: the chain is requesting data.
REQ-012 SHALL have port `led_request__first`, input, 1 bit: the request is for the first LED of a frame.
REQ-013 SHALL have port `led_request__led_number`, input, 8 bits: requested LED index.
REQ-014 SHALL have ports `led_data__valid`, `led_data__last`, outputs, 1 bit each: data response strobe and end-of-chain flag.
REQ-015 SHALL have ports `led_data__red`, `led_data__green`, `led_data__blue`, outputs, 8 bits each: colour components.
REQ-016 SHALL have port `divider_400ns`, output, 8 bits: registered copy of `cfg_divider`.
REQ-017 SHALL have port `swap_pending`, output, 1 bit: a swap has been requested and not yet applied.
REQ-018 SHALL have port `frame_count`, output, 8 bits: number of completed frames, wrapping.

Function
REQ-019 SHALL implement a three-state machine: IDLE, RESPOND, WAIT_DROP.
REQ-020 IDLE -> RESPOND SHALL occur when `led_request__ready` = 1; at the same edge the block SHALL capture `led_number` and `first`.
REQ-021 In RESPOND, `led_data__valid` SHALL be 1 for exactly one cycle, one cycle after `ready` is seen; the state then moves to WAIT_DROP.
REQ-022 WAIT_DROP -> IDLE SHALL occur only when `ready` = 0, so that exactly one response is given per request.
REQ-023 Response data SHALL be front-bank entry `led_number[3:0]` when `led_number` < `cfg_num_leds`; otherwise it SHALL be 0,0,0.
REQ-024 `led_data__last` SHALL be 1 when `led_number` >= `cfg_num_leds` - 1, compared at 9-bit width; `cfg_num_leds` = 0 gives last = 1 with black on every request.
REQ-025 `led_data__*` SHALL hold their values while valid = 0; consumers sample them only when valid = 1.
REQ-026 A host write SHALL update the back bank at the clock edge; writes SHALL never alter the front bank.
REQ-027 `host_swap_req` SHALL set `swap_pending`.
REQ-028 The swap SHALL be applied at the IDLE->RESPOND edge of a request with `first` = 1, and it SHALL clear `swap_pending`.
  - The response to that same first request SHALL use the new front bank.
REQ-029 If `host_swap_req` and a first-request capture coincide, the swap SHALL be applied and `swap_pending` SHALL end at 0.
REQ-030 If a host write coincides with the swap edge, the write SHALL land in the pre-swap back bank, which becomes the front bank.
REQ-031 `frame_count` SHALL increment (mod 256) in the cycle `led_data__valid` = 1 with `led_data__last` = 1.
REQ-032 `divider_400ns` SHALL register `cfg_divider` every enabled cycle, with 1-cycle latency.
REQ-033 While `clk__enable` = 0, all state SHALL hold.

Reset
REQ-034 While `reset_n` = 0 the following SHALL hold, immediately and regardless of clock:
  - state = IDLE;
  - `led_data__valid` = 0, `led_data__last` = 0;
  - red, green, blue = 0;
  - `swap_pending` = 0, `frame_count` = 0;
  - `divider_400ns` = 0;
  - front-bank select = bank 0.
REQ-035 Both banks SHALL reset to all zeros.
REQ-036 Reset asserted mid-response SHALL drop `valid` at once; after release the block SHALL wait in IDLE for a new `ready`.

Verification
REQ-037 Scenario: `cfg_num_leds` = 3; write back idx 0/1/2 = 0x110000/0x002200/0x000033; pulse swap; requests 0 (first), 1, 2 -> responses 11/00/00, 00/22/00, 00/00/33; last only on LED 2; `frame_count` = 1.
REQ-038 Scenario: `ready` held high for 10 cycles -> exactly one valid pulse, in cycle 2.
REQ-039 Scenario: `cfg_num_leds` = 2 and a request for LED 5 -> black with last = 1; with `cfg_num_leds` = 0 and a request for LED 0 -> black with last = 1.
REQ-040 Scenario: swap pulse in the same cycle as `ready` + `first` -> the response comes from the new bank and `swap_pending` = 0; a swap pulse mid-frame -> `swap_pending` = 1 until the next first request.
REQ-041 Scenario: write idx 1 = 0xFFFFFF during a frame with no swap -> output for LED 1 is unchanged until a swap is applied.
REQ-042 Scenario: assert `reset_n` = 0 during the RESPOND cycle -> `valid` drops asynchronously; `frame_count`, `swap_pending` and `divider_400ns` read 0.

Source files
------------

// File: rtl/led_ws2812_frame_controller.sv
// WS2812 frame controller: a double-buffered 16-LED colour frame that answers one
// chain request at a time; host writes fill the back bank, swaps apply at frame start.
module led_ws2812_frame_controller (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        host_wr_valid,
    input  logic [3:0]  host_wr_index,
    input  logic [23:0] host_wr_rgb,
    input  logic        host_swap_req,
    input  logic [4:0]  cfg_num_leds,
    input  logic [7:0]  cfg_divider,
    input  logic        led_request__ready,
    input  logic        led_request__first,
    input  logic [7:0]  led_request__led_number,
    output logic        led_data__valid,
    output logic        led_data__last,
    output logic [7:0]  led_data__red,
    output logic [7:0]  led_data__green,
    output logic [7:0]  led_data__blue,
    output logic [7:0]  divider_400ns,
    output logic        swap_pending,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESPOND   = 2'd1,
        WAIT_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] bank_q [2][16];
    logic        front_sel_q, front_sel_d;
    logic        back_sel;
    logic        swap_pending_q, swap_pending_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic [7:0]  divider_q;
    logic [23:0] rgb_q, rgb_d;
    logic        last_q, last_d;
    logic        capture;
    logic        swap_now;
    logic        in_range;
    logic        wr_bypass;
    logic [3:0]  rd_index;
    logic [23:0] rd_rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (clk__enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (led_request__ready) state_d = RESPOND;
            RESPOND:   state_d = WAIT_DROP;
            WAIT_DROP: if (!led_request__ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        led_data__valid = 1'b0;
        capture         = 1'b0;
        case (state_q)
            IDLE:    capture = led_request__ready;
            RESPOND: led_data__valid = 1'b1;
            default: ;
        endcase
    end

    // A swap lands on the capture edge of a first-LED request, so the lookup below
    // reads the post-swap front bank; a write on that same edge targets the bank
    // that is becoming front, hence the bypass.
    always_comb begin
        back_sel       = ~front_sel_q;
        swap_now       = capture && led_request__first && (swap_pending_q || host_swap_req);
        front_sel_d    = front_sel_q ^ swap_now;
        rd_index       = led_request__led_number[3:0];
        wr_bypass      = swap_now && host_wr_valid && (host_wr_index == rd_index);
        rd_rgb         = wr_bypass ? host_wr_rgb : bank_q[front_sel_d][rd_index];
        in_range       = ({3'b000, cfg_num_leds} > led_request__led_number);
        rgb_d          = rgb_q;
        last_d         = last_q;
        if (capture) begin
            rgb_d  = in_range ? rd_rgb : 24'h000000;
            last_d = (({1'b0, led_request__led_number} + 9'd1) >= {4'b0000, cfg_num_leds});
        end
        swap_pending_d = swap_now ? 1'b0 : (swap_pending_q | host_swap_req);
        frame_count_d  = frame_count_q;
        if (led_data__valid && last_q) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            frame_count_q  <= 8'd0;
            divider_q      <= 8'd0;
            rgb_q          <= 24'h000000;
            last_q         <= 1'b0;
        end else if (clk__enable) begin
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            frame_count_q  <= frame_count_d;
            divider_q      <= cfg_divider;
            rgb_q          <= rgb_d;
            last_q         <= last_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    bank_q[b][i] <= 24'h000000;
                end
            end
        end else if (clk__enable && host_wr_valid) begin
            bank_q[back_sel][host_wr_index] <= host_wr_rgb;
        end
    end

    assign led_data__last  = last_q;
    assign led_data__red   = rgb_q[23:16];
    assign led_data__green = rgb_q[15:8];
    assign led_data__blue  = rgb_q[7:0];
    assign divider_400ns   = divider_q;
    assign swap_pending    = swap_pending_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_led_ws2812_frame_controller.sv
// Scoreboard bench for led_ws2812_frame_controller: a frame/bank reference model
// pushes expected responses, a negedge monitor pops them whenever valid is seen.
module tb_led_ws2812_frame_controller;

    logic        clk = 1'b0;
    logic        clk__enable;
    logic        reset_n;
    logic        host_wr_valid;
    logic [3:0]  host_wr_index;
    logic [23:0] host_wr_rgb;
    logic        host_swap_req;
    logic [4:0]  cfg_num_leds;
    logic [7:0]  cfg_divider;
    logic        led_request__ready;
    logic        led_request__first;
    logic [7:0]  led_request__led_number;
    logic        led_data__valid;
    logic        led_data__last;
    logic [7:0]  led_data__red;
    logic [7:0]  led_data__green;
    logic [7:0]  led_data__blue;
    logic [7:0]  divider_400ns;
    logic        swap_pending;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    led_ws2812_frame_controller dut (
        .clk                     (clk),
        .clk__enable             (clk__enable),
        .reset_n                 (reset_n),
        .host_wr_valid           (host_wr_valid),
        .host_wr_index           (host_wr_index),
        .host_wr_rgb             (host_wr_rgb),
        .host_swap_req           (host_swap_req),
        .cfg_num_leds            (cfg_num_leds),
        .cfg_divider             (cfg_divider),
        .led_request__ready      (led_request__ready),
        .led_request__first      (led_request__first),
        .led_request__led_number (led_request__led_number),
        .led_data__valid         (led_data__valid),
        .led_data__last          (led_data__last),
        .led_data__red           (led_data__red),
        .led_data__green         (led_data__green),
        .led_data__blue          (led_data__blue),
        .divider_400ns           (divider_400ns),
        .swap_pending            (swap_pending),
        .frame_count             (frame_count)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        last;
        logic        pend;
        logic [7:0]  frames;
    } exp_t;

    exp_t        expQ[$];
    logic [23:0] mBank [2][16];
    bit          mFront;
    bit          mPending;
    logic [7:0]  mFrames;
    logic [7:0]  lastDiv;
    bit          sideRandom;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++)
                mBank[b][i] = 24'h0;
        mFront   = 1'b0;
        mPending = 1'b0;
        mFrames  = 8'd0;
        lastDiv  = 8'd0;
    endtask

    // Behaviour of one enabled clock edge, from the block's documented rules.
    task automatic stepModel(input bit capture);
        int          idx;
        int          n;
        logic [23:0] rgb;
        logic        last;
        if (host_wr_valid) mBank[!mFront][host_wr_index] = host_wr_rgb;
        if (capture && led_request__first && (mPending || host_swap_req)) begin
            mFront   = !mFront;
            mPending = 1'b0;
        end else if (host_swap_req) begin
            mPending = 1'b1;
        end
        if (capture) begin
            idx  = int'(led_request__led_number);
            n    = int'(cfg_num_leds);
            rgb  = (idx < n) ? mBank[mFront][led_request__led_number[3:0]] : 24'h0;
            last = (idx >= n - 1);
            expQ.push_back('{rgb, last, mPending, mFrames});
            if (last) mFrames = mFrames + 8'd1;
        end
        lastDiv = cfg_divider;
    endtask

    task automatic tick(input bit capture);
        if (clk__enable) stepModel(capture);
        @(posedge clk);
        #1;
        checkOutput("divider", divider_400ns, lastDiv);
        @(negedge clk);
    endtask

    task automatic randomSide();
        if (sideRandom) begin
            host_wr_valid = ($urandom_range(0, 2) == 0);
            host_wr_index = 4'($urandom_range(0, 15));
            host_wr_rgb   = 24'($urandom);
            host_swap_req = ($urandom_range(0, 9) == 0);
        end else begin
            host_wr_valid = 1'b0;
            host_swap_req = 1'b0;
        end
        cfg_divider = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [7:0] idx, input bit first, input int hold, input bit swapAtCapture);
        for (int c = 0; c < hold; c++) begin
            randomSide();
            if (c == 0 && swapAtCapture) host_swap_req = 1'b1;
            led_request__ready      = 1'b1;
            led_request__led_number = idx;
            led_request__first      = first;
            tick(c == 0);
        end
        led_request__ready = 1'b0;
        led_request__first = 1'b0;
        for (int c = 0; c < 2; c++) begin
            randomSide();
            tick(1'b0);
        end
    endtask

    task automatic hostWrite(input logic [3:0] idx, input logic [23:0] rgb);
        randomSide();
        host_wr_valid = 1'b1;
        host_wr_index = idx;
        host_wr_rgb   = rgb;
        tick(1'b0);
    endtask

    task automatic swapPulse();
        randomSide();
        host_swap_req = 1'b1;
        tick(1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && led_data__valid) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_valid: got valid=1, expected no response pending");
            end else begin
                e = expQ.pop_front();
                checkOutput("rgb", {led_data__red, led_data__green, led_data__blue}, e.rgb);
                checkOutput("last", led_data__last, e.last);
                checkOutput("swap_pending_at_resp", swap_pending, e.pend);
                checkOutput("frame_count_at_resp", frame_count, e.frames);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clk__enable = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_index = 4'd0;
        host_wr_rgb = 24'h0;
        host_swap_req = 1'b0;
        cfg_num_leds = 5'd0;
        cfg_divider = 8'd0;
        led_request__ready = 1'b0;
        led_request__first = 1'b0;
        led_request__led_number = 8'd0;
        sideRandom = 1'b0;
        modelReset();

        #3;
        checkOutput("reset_valid", led_data__valid, 1'b0);
        checkOutput("reset_last", led_data__last, 1'b0);
        checkOutput("reset_rgb", {led_data__red, led_data__green, led_data__blue}, 24'h0);
        checkOutput("reset_swap_pending", swap_pending, 1'b0);
        checkOutput("reset_frame_count", frame_count, 8'd0);
        checkOutput("reset_divider", divider_400ns, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic three-LED frame
        cfg_num_leds = 5'd3;
        hostWrite(4'd0, 24'h110000);
        hostWrite(4'd1, 24'h002200);
        hostWrite(4'd2, 24'h000033);
        swapPulse();
        checkOutput("pending_after_pulse", swap_pending, 1'b1);
        applyStimulus(8'd0, 1'b1, 1, 1'b0);
        checkOutput("led0_rgb", {led_data__red, led_data__green, led_data__blue}, 24'h110000);
        checkOutput("led0_last", led_data__last, 1'b0);
        applyStimulus(8'd1, 1'b0, 1, 1'b0);
        applyStimulus(8'd2, 1'b0, 1, 1'b0);
        checkOutput("led2_rgb", {led_data__red, led_data__green, led_data__blue}, 24'h000033);
        checkOutput("led2_last", led_data__last, 1'b1);
        checkOutput("frames_after_first_frame", frame_count, 8'd1);

        // Ready held high: one pulse only, in the cycle after ready is seen
        for (int c = 0; c < 10; c++) begin
            randomSide();
            led_request__ready      = 1'b1;
            led_request__led_number = 8'd1;
            led_request__first      = 1'b0;
            tick(c == 0);
            checkOutput("single_pulse", led_data__valid, (c == 0));
        end
        led_request__ready = 1'b0;
        randomSide(); tick(1'b0);
        randomSide(); tick(1'b0);

        // Out-of-range and empty chain
        cfg_num_leds = 5'd2;
        applyStimulus(8'd5, 1'b0, 2, 1'b0);
        checkOutput("oor_rgb", {led_data__red, led_data__green, led_data__blue}, 24'h0);
        checkOutput("oor_last", led_data__last, 1'b1);
        cfg_num_leds = 5'd0;
        applyStimulus(8'd0, 1'b0, 1, 1'b0);
        checkOutput("empty_rgb", {led_data__red, led_data__green, led_data__blue}, 24'h0);
        checkOutput("empty_last", led_data__last, 1'b1);

        // Swap coincident with first request, then a mid-frame swap
        cfg_num_leds = 5'd4;
        hostWrite(4'd0, 24'hABCDEF);
        applyStimulus(8'd0, 1'b1, 1, 1'b1);
        checkOutput("coincident_swap_rgb", {led_data__red, led_data__green, led_data__blue}, 24'hABCDEF);
        checkOutput("coincident_swap_pending", swap_pending, 1'b0);
        applyStimulus(8'd1, 1'b0, 1, 1'b0);
        swapPulse();
        checkOutput("midframe_pending", swap_pending, 1'b1);
        applyStimulus(8'd2, 1'b0, 1, 1'b0);
        checkOutput("midframe_pending_held", swap_pending, 1'b1);
        applyStimulus(8'd0, 1'b1, 1, 1'b0);
        checkOutput("pending_cleared", swap_pending, 1'b0);

        // Back-bank write stays invisible until swapped in
        hostWrite(4'd1, 24'hFFFFFF);
        applyStimulus(8'd1, 1'b0, 1, 1'b0);
        swapPulse();
        applyStimulus(8'd0, 1'b1, 1, 1'b0);
        applyStimulus(8'd1, 1'b0, 1, 1'b0);
        checkOutput("swapped_in_white", {led_data__red, led_data__green, led_data__blue}, 24'hFFFFFF);

        // Clock enable low: nothing moves
        clk__enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            randomSide();
            led_request__ready      = 1'b1;
            led_request__led_number = 8'd0;
            led_request__first      = 1'b1;
            host_swap_req           = 1'b1;
            host_wr_valid           = 1'b1;
            tick(1'b0);
            checkOutput("disabled_valid", led_data__valid, 1'b0);
            checkOutput("disabled_pending", swap_pending, mPending);
            checkOutput("disabled_frames", frame_count, mFrames);
        end
        led_request__ready = 1'b0;
        led_request__first = 1'b0;
        clk__enable = 1'b1;
        randomSide(); tick(1'b0);
        randomSide(); tick(1'b0);

        // Randomised frames
        sideRandom = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(0, 16);
            cfg_num_leds = 5'(n);
            for (int led = 0; led <= n; led++) begin
                logic [7:0] idx;
                idx = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(led);
                applyStimulus(idx, (led == 0), $urandom_range(1, 3), ($urandom_range(0, 4) == 0));
            end
        end
        sideRandom = 1'b0;

        // Reset asserted during the response cycle
        cfg_num_leds = 5'd4;
        swapPulse();
        randomSide();
        led_request__ready      = 1'b1;
        led_request__led_number = 8'd0;
        led_request__first      = 1'b0;
        tick(1'b1);
        checkOutput("pre_reset_valid", led_data__valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_valid", led_data__valid, 1'b0);
        checkOutput("mid_reset_frames", frame_count, 8'd0);
        checkOutput("mid_reset_pending", swap_pending, 1'b0);
        checkOutput("mid_reset_divider", divider_400ns, 8'd0);
        modelReset();
        expQ.delete();
        led_request__ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        randomSide(); tick(1'b0);
        checkOutput("post_reset_idle", led_data__valid, 1'b0);
        applyStimulus(8'd2, 1'b0, 1, 1'b0);

        for (int c = 0; c < 3; c++) begin
            randomSide();
            tick(1'b0);
        end
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("frames_final", frame_count, mFrames);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
